// File: rtl/spi_rx.sv
// spi_rx: oversampling SPI receiver, reassembles LSB-first frames into parallel words
module spi_rx #(
    parameter int DATA_W      = 12,
    parameter int SKIP_EDGES  = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              done,
    output logic              err,
    output logic              busy
);
    localparam int BW = $clog2(DATA_W);
    localparam int EW = SKIP_EDGES > 1 ? $clog2(SKIP_EDGES) : 1;

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, LAST, HOLD} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   prev_sclk_q;
    state_t                 state_q, state_d;
    logic [EW-1:0]          edge_q, edge_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_W-1:0]      sr_q, sr_d, dout_q, dout_d;
    logic                   done_q, done_d, err_q, err_d, busy_q, busy_d;

    wire sclk_s = sclk_sync_q[SYNC_STAGES-1];
    wire cs_s   = cs_sync_q[SYNC_STAGES-1];
    wire mosi_s = mosi_sync_q[SYNC_STAGES-1];
    wire fall   = prev_sclk_q & ~sclk_s;

    always_comb begin
        state_d = state_q;
        edge_d  = edge_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            IDLE: if (!cs_s) begin
                state_d = SKIP_EDGES == 0 ? SHIFT : LEAD;
                edge_d  = '0;
                bit_d   = '0;
                sr_d    = '0;
                busy_d  = 1'b1;
            end
            LEAD: if (cs_s) begin
                state_d = IDLE;
                err_d   = 1'b1;
                busy_d  = 1'b0;
            end else if (fall) begin
                state_d = edge_q == EW'(SKIP_EDGES - 1) ? SHIFT : LEAD;
                edge_d  = edge_q + 1'b1;
                bit_d   = '0;
            end
            SHIFT: if (cs_s) begin
                state_d = IDLE;
                err_d   = 1'b1;
                busy_d  = 1'b0;
            end else if (fall) begin
                sr_d[bit_q] = mosi_s;
                bit_d       = bit_q + 1'b1;
                state_d     = bit_q == BW'(DATA_W - 1) ? LAST : SHIFT;
            end
            // word is complete; a cs rise arriving now is a normal frame end
            LAST: begin
                state_d = HOLD;
                dout_d  = sr_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            HOLD:    state_d = cs_s ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            prev_sclk_q <= 1'b0;
            state_q     <= IDLE;
            edge_q      <= '0;
            bit_q       <= '0;
            sr_q        <= '0;
            dout_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            prev_sclk_q <= sclk_s;
            state_q     <= state_d;
            edge_q      <= edge_d;
            bit_q       <= bit_d;
            sr_q        <= sr_d;
            dout_q      <= dout_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign dout = dout_q;
    assign done = done_q;
    assign err  = err_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_spi_rx.sv
// tb_spi_rx: table-driven and randomized frame checks against a word-level receiver model
module tb_spi_rx;
    logic        clk = 1'b0, rst = 1'b0, sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
    logic [11:0] dout;
    logic        done, err, busy;
    int          n_tests = 0, n_fail = 0;
    int          done_cnt = 0, err_cnt = 0, busy_cnt = 0;
    logic [11:0] exp_dout;

    spi_rx dut (.clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
                .dout(dout), .done(done), .err(err), .busy(busy));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (busy) busy_cnt++;
    end

    typedef struct {
        logic [11:0] d;
        int          nb;
        int          h;
        int          gap;
        logic [11:0] ed;
        int          edone;
        int          eerr;
    } vec_t;

    vec_t tbl[7];

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [11:0] d, input int nb, input int h, input int gap);
        cs = 1'b0;
        wait_clk(h);
        sclk = 1'b1;
        wait_clk(h);
        sclk = 1'b0;
        wait_clk(h);
        for (int i = 0; i < nb; i++) begin
            sclk = 1'b1;
            mosi = d[i];
            wait_clk(h);
            if (i == nb - 1) chk("busy_mid", int'(busy), 1);
            sclk = 1'b0;
            wait_clk(h);
        end
        cs = 1'b1;
        wait_clk(gap);
    endtask

    task automatic run_frame(input logic [11:0] d, input int nb, input int h, input int gap,
                             input logic [11:0] ed, input int edone, input int eerr);
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send(d, nb, h, gap);
        chk("dout", int'(dout), int'(ed));
        chk("done_pulses", done_cnt - d0, edone);
        chk("err_pulses", err_cnt - e0, eerr);
        chk("busy_after", int'(busy), 0);
    endtask

    initial begin
        int d0, e0, b0, nb, h;
        logic [11:0] rd;
        tbl[0] = '{12'hA5C, 12, 51, 20, 12'hA5C, 1, 0};
        tbl[1] = '{12'h001, 12, 51, 20, 12'h001, 1, 0};
        tbl[2] = '{12'h800, 12, 51, 20, 12'h800, 1, 0};
        tbl[3] = '{12'hFFF, 12, 51, 3,  12'hFFF, 1, 0};
        tbl[4] = '{12'h000, 12, 51, 20, 12'h000, 1, 0};
        tbl[5] = '{12'hFFF, 5,  51, 20, 12'h000, 0, 1};
        tbl[6] = '{12'h3C3, 12, 51, 20, 12'h3C3, 1, 0};

        wait_clk(3);
        chk("rst_dout", int'(dout), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b1;
        wait_clk(5);

        for (int i = 0; i < 7; i++)
            run_frame(tbl[i].d, tbl[i].nb, tbl[i].h, tbl[i].gap, tbl[i].ed, tbl[i].edone, tbl[i].eerr);
        exp_dout = 12'h3C3;

        d0 = done_cnt;
        e0 = err_cnt;
        b0 = busy_cnt;
        for (int i = 0; i < 30; i++) begin
            sclk = ~sclk;
            mosi = 1'($urandom);
            wait_clk(5);
        end
        sclk = 1'b0;
        wait_clk(10);
        chk("idle_busy", busy_cnt - b0, 0);
        chk("idle_done", done_cnt - d0, 0);
        chk("idle_err", err_cnt - e0, 0);
        chk("idle_dout", int'(dout), int'(exp_dout));

        cs = 1'b0;
        wait_clk(20);
        sclk = 1'b1;
        wait_clk(20);
        sclk = 1'b0;
        wait_clk(20);
        for (int i = 0; i < 6; i++) begin
            sclk = 1'b1;
            mosi = 1'(i);
            wait_clk(20);
            sclk = 1'b0;
            wait_clk(20);
        end
        chk("pre_rst_busy", int'(busy), 1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_dout", int'(dout), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_err", int'(err), 0);
        chk("mid_rst_busy", int'(busy), 0);
        cs = 1'b1;
        wait_clk(5);
        rst = 1'b1;
        wait_clk(5);
        run_frame(12'h5A5, 12, 51, 20, 12'h5A5, 1, 0);
        exp_dout = 12'h5A5;

        for (int i = 0; i < 20; i++) begin
            rd = 12'($urandom);
            nb = $urandom_range(0, 3) == 0 ? $urandom_range(0, 11) : 12;
            h  = $urandom_range(4, 20);
            if (nb == 12) exp_dout = rd;
            run_frame(rd, nb, h, $urandom_range(10, 15), exp_dout, nb == 12 ? 1 : 0, nb == 12 ? 0 : 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_rx.md
Name: spi_rx

Overview:
- SPI receive end for the 12-bit LSB-first serial link driven by the team's SPI transmitter.
- Oversamples sclk, cs and mosi in the system clk domain and reassembles each frame into a parallel word.
- Presents the word with a one-cycle done strobe and flags truncated frames.
- Sits on the far side of the link, on the consumer side of the spi_if bus.

Parameters:
- DATA_W, 12: frame width in bits. Bits arrive LSB first.
- SKIP_EDGES, 1: number of sclk falling edges discarded after cs assertion, before the first data bit.
- SYNC_STAGES, 2: flip-flop stages in each input synchronizer. Minimum 2.

Ports:
- clk  input  1  system clock. All logic is on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- sclk  input  1  serial clock from the transmitter. Asynchronous to clk.
- cs  input  1  chip select, active-low, asynchronous.
- mosi  input  1  serial data, asynchronous.
- dout  output  DATA_W  last complete received word.
- done  output  1  one-cycle pulse: dout has just been updated.
- err  output  1  one-cycle pulse: frame aborted by cs deassertion before DATA_W bits were received.
- busy  output  1  high while a frame is in progress (cs asserted and not yet complete).

Behaviour:
- Reset: asynchronous clear while rst=0. Values in reset: dout=0, done=0, err=0, busy=0, state=IDLE, bit counter=0, shift register=0. Synchronizers are cleared to: sclk 0, cs 1, mosi 0.
- Synchronization: sclk, cs and mosi each pass through SYNC_STAGES flops. All three have equal delay, so their relative alignment is preserved.
- Falling-edge detection: fall = prev_sclk_s & ~sclk_s, where prev_sclk_s is one extra register stage on the synchronized sclk.
- Sampling: mosi_s is sampled only on a cycle where fall=1. The transmitter changes mosi on sclk rising edges, so the falling edge is mid-bit.
- State IDLE:
  - busy=0; sclk activity is ignored.
  - cs_s=0 -> LEAD, edge counter=0, busy=1.
- State LEAD:
  - Each fall increments the edge counter.
  - At SKIP_EDGES edges -> SHIFT, bit counter=0.
  - If SKIP_EDGES=0, go straight to SHIFT.
- State SHIFT:
  - Each fall: shift register bit[bitcnt] <= mosi_s, bitcnt++.
  - On the fall that captures bit DATA_W-1: next cycle dout <= assembled word, done=1 for exactly one cycle, busy=0, state -> HOLD.
- State HOLD:
  - Further sclk edges are ignored.
  - cs_s=1 -> IDLE.
  - dout holds its value until the next done.
- Abort:
  - cs_s=1 in LEAD or SHIFT -> err=1 for one cycle, then IDLE, busy=0.
  - Partial word is discarded; dout and done are unchanged.
- Simultaneous events:
  - fall and cs_s rising in the same cycle: cs wins (abort rule) and the fall is not sampled.
  - The fall that completes the word takes effect even if cs rises in the next cycle; no err in that case.
- Back-to-back frames: cs low again in the first IDLE cycle after HOLD starts a new frame. No dead cycles are required beyond the state transition.
- Latency: done asserts SYNC_STAGES+2 clk cycles after the physical sclk falling edge of the last bit (synchronizer + edge register + output register).
- Input rate: minimum sclk half-period is 4 clk. The transmitter's half-period of 51 clk is well within this.
- Reset mid-frame: everything returns immediately to the reset values. After rst is released, a frame already in progress (cs still low) enters LEAD on the current edges. That frame is treated as a fresh frame and is not resynchronized to its true start; the bench must not check its contents.
- dout, done, err and busy are all registered outputs.

Test Plan:
- Single frame, din=12'hA5C, sclk half-period 51 clk, 1 lead edge -> exactly one done pulse, dout=12'hA5C, err never high, busy high throughout the frame.
- Bit order: frames 12'h001, then 12'h800 -> dout=12'h001, then dout=12'h800. Confirms LSB-first placement.
- Back-to-back frames 12'hFFF then 12'h000 with minimal cs-high gap -> two done pulses, dout=12'hFFF then dout=12'h000.
- Abort: cs raised after 5 data falls -> err=1 for one cycle, no done, dout keeps its previous value (12'h000). A following good frame 12'h3C3 -> dout=12'h3C3.
- sclk toggling for 30 edges with cs=1 -> busy, done and err all stay 0, dout unchanged.
- rst driven 0 mid-frame after 6 bits, asynchronously between clk edges -> dout, done, err and busy are 0 immediately. A subsequent clean frame 12'h5A5 -> dout=12'h5A5.
